// File: rtl/blit_pkg.sv
// Shared types and defaults for the blitter memory responder.
// The FSM state and grant encodings are shared by the top and its arbiter.
package blit_pkg;

    localparam int BLIT_ADDR_W    = 26;
    localparam int BLIT_BURST_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_DATA
    } state_t;

    typedef enum logic {
        GRANT_WRITE,
        GRANT_READ
    } grant_t;

endpackage

// File: rtl/blit_rr_arbiter.sv
// Two-way round-robin arbiter between the blitter write and read ports.
// A tie goes to the port that did not win last; last_grant moves only on update.
module blit_rr_arbiter
    import blit_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   request_write,
    input  logic   request_read,
    input  logic   update,
    output grant_t grant,
    output logic   grant_valid
);

    grant_t last_grant_reg;
    grant_t last_grant_next;

    always_comb begin
        grant_valid     = request_write | request_read;
        grant           = GRANT_WRITE;
        if (request_write && request_read) begin
            grant = (last_grant_reg == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
        end else if (request_read) begin
            grant = GRANT_READ;
        end
        last_grant_next = last_grant_reg;
        if (update && grant_valid) begin
            last_grant_next = grant;
        end
    end

    // Resetting to WRITE makes a read win the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_reg <= GRANT_WRITE;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/blit_mem_responder.sv
// Memory-side responder for the blitter: arbitrates its write and read ports,
// issues single writes / fixed-length read bursts and returns acks and beats.
module blit_mem_responder
    import blit_pkg::*;
#(
    parameter int BURST_LEN = BLIT_BURST_LEN,
    parameter int ADDR_W    = BLIT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              blitw_request,
    input  logic [ADDR_W-1:0] blitw_address,
    input  logic [31:0]       blitw_wdata,
    input  logic [3:0]        blitw_byte_en,
    output logic              blitw_ack,
    input  logic              blitr_request,
    input  logic [ADDR_W-1:0] blitr_address,
    output logic              blitr_ack,
    output logic [31:0]       blitr_rdata,
    output logic              blitr_valid,
    output logic              blitr_complete,
    output logic              mem_request,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t              state_reg, state_next;
    logic                mem_request_reg, mem_request_next;
    logic                mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0]   mem_address_reg, mem_address_next;
    logic [31:0]         mem_wdata_reg, mem_wdata_next;
    logic [3:0]          mem_byte_en_reg, mem_byte_en_next;
    logic [31:0]         rdata_reg, rdata_next;
    logic                valid_reg, valid_next;
    logic                complete_reg, complete_next;
    logic [CNT_W-1:0]    beat_count_reg, beat_count_next;

    grant_t              grant;
    logic                grant_valid;
    logic                grant_update;
    logic [ADDR_W-1:0]   write_address;
    logic [ADDR_W-1:0]   read_address;

    // Writes are word-aligned; reads are aligned to the whole burst.
    assign write_address = blitw_address & ~ADDR_W'(3);
    assign read_address  = blitr_address & ~ADDR_W'(BURST_LEN * 4 - 1);

    blit_rr_arbiter u_arbiter (
        .clock         (clock),
        .reset         (reset),
        .request_write (blitw_request),
        .request_read  (blitr_request),
        .update        (grant_update),
        .grant         (grant),
        .grant_valid   (grant_valid)
    );

    always_comb begin
        state_next       = state_reg;
        mem_request_next = mem_request_reg;
        mem_write_next   = mem_write_reg;
        mem_address_next = mem_address_reg;
        mem_wdata_next   = mem_wdata_reg;
        mem_byte_en_next = mem_byte_en_reg;
        rdata_next       = rdata_reg;
        valid_next       = 1'b0;
        complete_next    = 1'b0;
        beat_count_next  = beat_count_reg;
        grant_update     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    grant_update     = 1'b1;
                    mem_request_next = 1'b1;
                    if (grant == GRANT_WRITE) begin
                        mem_write_next   = 1'b1;
                        mem_address_next = write_address;
                        mem_wdata_next   = blitw_wdata;
                        mem_byte_en_next = blitw_byte_en;
                        state_next       = WRITE;
                    end else begin
                        mem_write_next   = 1'b0;
                        mem_address_next = read_address;
                        mem_wdata_next   = '0;
                        mem_byte_en_next = '0;
                        state_next       = READ_ISSUE;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    mem_request_next = 1'b0;
                    state_next       = IDLE;
                end
            end
            READ_ISSUE: begin
                if (mem_ready) begin
                    mem_request_next = 1'b0;
                    beat_count_next  = '0;
                    state_next       = READ_DATA;
                end
            end
            READ_DATA: begin
                // Beats are only accepted here; stray ones elsewhere are dropped.
                if (mem_rvalid) begin
                    rdata_next      = mem_rdata;
                    valid_next      = 1'b1;
                    beat_count_next = beat_count_reg + CNT_W'(1);
                    if (beat_count_reg == LAST_BEAT) begin
                        complete_next = 1'b1;
                        state_next    = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            mem_request_reg <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
            mem_byte_en_reg <= '0;
            rdata_reg       <= '0;
            valid_reg       <= 1'b0;
            complete_reg    <= 1'b0;
            beat_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            mem_request_reg <= mem_request_next;
            mem_write_reg   <= mem_write_next;
            mem_address_reg <= mem_address_next;
            mem_wdata_reg   <= mem_wdata_next;
            mem_byte_en_reg <= mem_byte_en_next;
            rdata_reg       <= rdata_next;
            valid_reg       <= valid_next;
            complete_reg    <= complete_next;
            beat_count_reg  <= beat_count_next;
        end
    end

    // Acks follow mem_ready in the accept cycle so the blitter can pop at once.
    assign blitw_ack      = (state_reg == WRITE) && mem_request_reg && mem_ready;
    assign blitr_ack      = (state_reg == READ_ISSUE) && mem_request_reg && mem_ready;

    assign mem_request    = mem_request_reg;
    assign mem_write      = mem_write_reg;
    assign mem_address    = mem_address_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign mem_byte_en    = mem_byte_en_reg;
    assign blitr_rdata    = rdata_reg;
    assign blitr_valid    = valid_reg;
    assign blitr_complete = complete_reg;

endmodule

// File: doc/blit_mem_responder.md
Name: blit_mem_responder

Overview:
- Memory-side responder for the blitter's two bus masters: the write port (`blitw_*`) and the read port (`blitr_*`).
- Arbitrates between them and issues single-word writes and fixed-length read bursts to the SDRAM controller port.
- Returns the acks, read data beats and burst-complete strobe the blitter expects.
- Sits between the blitter and the SDRAM controller's arbiter.

Parameters:
- BURST_LEN, 8, words per read burst (power of two ≥2); a read request is acked once, then BURST_LEN valid beats follow.
- ADDR_W, 26, byte address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- blitw_request  in  1  write pending; held until ack
- blitw_address  in  ADDR_W  word-aligned byte address; bits [1:0] are ignored
- blitw_wdata  in  32  write data
- blitw_byte_en  in  4  byte enables
- blitw_ack  out  1  one-cycle pulse: write accepted by memory, blitter pops its FIFO
- blitr_request  in  1  read burst pending; held until ack
- blitr_address  in  ADDR_W  burst address; low log2(BURST_LEN*4) bits are forced to 0
- blitr_ack  out  1  one-cycle pulse: read command accepted by memory
- blitr_rdata  out  32  read beat data
- blitr_valid  out  1  read beat valid
- blitr_complete  out  1  pulses together with the last blitr_valid of a burst
- mem_request  out  1  command valid to SDRAM controller
- mem_write  out  1  1 = write, 0 = read burst
- mem_address  out  ADDR_W  command address
- mem_wdata  out  32  write data
- mem_byte_en  out  4  write byte enables
- mem_ready  in  1  controller accepts command this cycle when mem_request=1
- mem_rdata  in  32  read beat
- mem_rvalid  in  1  read beat valid

Behaviour:
- Reset values:
  - All outputs are 0.
  - State = IDLE, last_grant = WRITE, so a read wins the first tie.
- IDLE:
  - Samples the requests.
  - If only one port is requesting, grant it.
  - If both are requesting, grant the port opposite to last_grant (round-robin).
  - On a grant, register address/data/byte_en/mem_write into the mem_* outputs, set mem_request=1 and update last_grant.
  - Next state is WRITE or READ_ISSUE.
  - Latency from request to mem_request: 1 cycle.
- WRITE:
  - Hold the mem_* outputs stable while mem_ready=0.
  - In the cycle mem_request&&mem_ready, assert blitw_ack (combinational from mem_ready, qualified by state).
  - Next cycle: mem_request=0, state=IDLE.
  - A write occupies at least 2 cycles, so the blitter's request is never resampled in the ack cycle.
- READ_ISSUE:
  - Hold until mem_ready.
  - In the cycle mem_request&&mem_ready, assert blitr_ack and clear the beat counter.
  - Next state is READ_DATA with mem_request=0.
- READ_DATA:
  - Each mem_rvalid is registered into blitr_rdata/blitr_valid, one cycle later, and increments the beat counter (width log2(BURST_LEN)).
  - On the beat where counter==BURST_LEN-1, the registered output also carries blitr_complete=1 and the state returns to IDLE.
  - Writes are not granted during READ_DATA.
  - A blitr_request still asserted while in READ_DATA is ignored; the blitter cache deasserts its request after the ack.
- mem_rvalid outside READ_DATA is ignored and no blitr_valid is emitted (protocol error; simulation-only $display).
- blitr_valid/blitr_complete are 0 on every cycle without a beat. blitw_ack and blitr_ack are never both 1 in the same cycle.
- Address handling:
  - Write addresses are passed with [1:0] cleared.
  - Read addresses are passed with the burst-offset bits cleared.
  - No arithmetic overflow is possible; addresses are passed through unchanged otherwise.
- Reset mid-operation:
  - Immediate return to IDLE and all outputs to 0.
  - Any outstanding beats are dropped. The SDRAM controller shares the same reset, so no stale beats arrive afterwards.
- Simultaneous request deassertion is illegal before ack; behaviour is undefined and checked by assertion in the bench.

Decomposition:
- Shared package `blit_pkg`:
  - state enum {IDLE, WRITE, READ_ISSUE, READ_DATA}
  - BLIT_ADDR_W = 26
  - BLIT_BURST_LEN = 8
  - grant enum {GRANT_WRITE, GRANT_READ}
- One natural sub-module: `blit_rr_arbiter`, a 2-way round-robin arbiter with a last_grant register and an update enable.
- Beat counter and FSM stay in the top module.

Test Plan:
- Single write: blitw_request, addr 0x000123, byte_en 0010, wdata 0x0000AB00, mem_ready=1 → mem_request 1 cycle later with mem_address 0x000120 and mem_write=1; blitw_ack pulses once in the accept cycle; back in IDLE the cycle after.
- Read burst: blitr_request, addr 0x00105C, mem_ready=1, memory returns 8 beats 0x11..0x88 → mem_address 0x001040, blitr_ack pulses once, 8 blitr_valid beats with matching data each 1 cycle late, blitr_complete only on the 0x88 beat.
- Contention: both requests held continuously for 4 grants → grant order READ, WRITE, READ, WRITE; no double acks.
- Backpressure: mem_ready=0 for 5 cycles during WRITE → mem_* outputs stable throughout, blitw_ack only on the cycle mem_ready rises.
- Reset mid-burst: assert reset after beat 3 of 8 → all outputs 0 next cycle, state IDLE; a subsequent write completes normally.
- Throughput: 4 back-to-back writes with mem_ready=1 → one blitw_ack every 2 cycles, addresses delivered in order.
